// File: rtl/ref_clk_fwd_gen.sv
// Forwarded reference clock generator: divides CLK by a runtime-programmable
// ratio and drives the result plus a pad output enable. Start/stop never
// produces runt pulses, ratio changes land on period boundaries, and SYNC
// realigns the phase while running.
module ref_clk_fwd_gen #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int MIN_DIV     = 2
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 ENABLE,
    input  logic [DIV_WIDTH-1:0] DIV_VALUE,
    input  logic                 DIV_LOAD,
    input  logic                 SYNC,
    output logic                 CLK_OUT,
    output logic                 CLK_OUT_EN,
    output logic                 RUNNING,
    output logic                 DIV_ACK,
    output logic                 ERR_DIV
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pend_val_q, pend_val_d;
    logic                 pend_q, pend_d;
    logic                 clk_out_q, clk_out_d;
    logic                 out_en_q, out_en_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;

    logic                 load_ok;
    logic                 load_bad;
    logic                 eff_valid;
    logic [DIV_WIDTH-1:0] eff_pend;
    logic                 wrap;
    logic                 apply;
    logic [DIV_WIDTH-1:0] high_len;

    // A legal load in the same cycle as a boundary takes precedence over an
    // older pending value, so the "effective" pending ratio merges both.
    assign load_ok   = DIV_LOAD && (DIV_VALUE >= DIV_WIDTH'(MIN_DIV));
    assign load_bad  = DIV_LOAD && (DIV_VALUE <  DIV_WIDTH'(MIN_DIV));
    assign eff_valid = load_ok || pend_q;
    assign eff_pend  = load_ok ? DIV_VALUE : pend_val_q;
    assign wrap      = (cnt_q == (div_q - DIV_WIDTH'(1)));

    // Next-state, counter, ratio bookkeeping and registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        apply      = 1'b0;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        high_len   = '0;
        clk_out_d  = 1'b0;
        out_en_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                apply = eff_valid;
                cnt_d = '0;
                if (ENABLE) state_d = ST_START;
            end
            ST_START: begin
                // cnt doubles as the two-cycle lead-in timer here
                apply = eff_valid;
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DIV_WIDTH'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (SYNC) begin
                    cnt_d   = '0;
                    apply   = eff_valid;
                    state_d = ENABLE ? ST_RUN : ST_STOP;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
                    apply = wrap && eff_valid;
                    if (!ENABLE) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
                apply = wrap && eff_valid;
                if (ENABLE)    state_d = ST_RUN;
                else if (wrap) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load_ok) pend_val_d = DIV_VALUE;
        if (apply) begin
            div_d  = eff_pend;
            pend_d = 1'b0;
            err_d  = 1'b0;
        end else begin
            pend_d = eff_valid;
        end
        ack_d = apply;
        if (load_bad) err_d = 1'b1;

        // High phase is the ceiling half of the period, judged on the ratio
        // that will be in force in the cycle being produced.
        high_len  = div_d - (div_d >> 1);
        clk_out_d = ((state_d == ST_RUN) || (state_d == ST_STOP)) && (cnt_d < high_len);
        out_en_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            out_en_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            out_en_q   <= out_en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign CLK_OUT    = clk_out_q;
    assign CLK_OUT_EN = out_en_q;
    assign RUNNING    = (state_q == ST_RUN);
    assign DIV_ACK    = ack_q;
    assign ERR_DIV    = err_q;

endmodule
